// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Packs a valid/ready byte stream into big-endian 32-bit instruction words
//   and writes them into instruction memory.  The pipeline is held in reset
//   (cpu_rst=1) until a complete program has been loaded.
//
//   Optional feature macro: CHECKSUM_EN.  When defined, a 4-byte checksum
//   (XOR of all loaded words) follows the program.  The checksum is never
//   written to memory, and a mismatch sets err and returns to IDLE.
//
// Ports
//   clk, rst        clock / asynchronous active-high reset
//   start           1-cycle load request (ignored while busy)
//   num_words       program length in words, legal 1..DEPTH
//   byte_in         stream byte
//   byte_valid      stream byte valid
//   byte_ready      loader accepts a byte this cycle
//   Instr_IN        instruction word to I-mem
//   Instr_W_en      I-mem write strobe (one cycle per word)
//   I_W_Addr        I-mem write address
//   cpu_rst         pipeline reset, 1 = hold pipeline
//   busy            load in progress
//   done            program loaded, pipeline running
//   err             sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic [31:0]       Instr_IN,
   output logic              Instr_W_en,
   output logic [ADDR_W-1:0] I_W_Addr,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHK, S_RUN} state_t;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     wcnt_q, wcnt_d;
   logic [ADDR_W:0]     nwords_q, nwords_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [23:0]         shift_q, shift_d;
   logic [31:0]         word_q, word_d;
   logic [31:0]         csum_q, csum_d;

   logic                byte_ready_q, byte_ready_d;
   logic [31:0]         instr_in_q, instr_in_d;
   logic                instr_w_en_q, instr_w_en_d;
   logic [ADDR_W-1:0]   i_w_addr_q, i_w_addr_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                err_set, err_clr;
   logic                byte_acc;
   logic                start_legal;
   logic [31:0]         full_word;

   assign byte_acc    = byte_valid && byte_ready_q;
   assign start_legal = (num_words != '0) && (num_words <= DEPTH_W);
   assign full_word   = {shift_q, byte_in};

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         wcnt_q       <= '0;
         nwords_q     <= '0;
         bcnt_q       <= '0;
         shift_q      <= '0;
         word_q       <= '0;
         csum_q       <= '0;
         byte_ready_q <= 1'b0;
         instr_in_q   <= '0;
         instr_w_en_q <= 1'b0;
         i_w_addr_q   <= '0;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wcnt_q       <= wcnt_d;
         nwords_q     <= nwords_d;
         bcnt_q       <= bcnt_d;
         shift_q      <= shift_d;
         word_q       <= word_d;
         csum_q       <= csum_d;
         byte_ready_q <= byte_ready_d;
         instr_in_q   <= instr_in_d;
         instr_w_en_q <= instr_w_en_d;
         i_w_addr_q   <= i_w_addr_d;
         cpu_rst_q    <= cpu_rst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wcnt_d   = wcnt_q;
      nwords_d = nwords_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      word_d   = word_q;
      csum_d   = csum_q;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      case (state_q)
         S_IDLE, S_RUN: begin
            if (start) begin
               if (start_legal) begin
                  state_d  = S_LOAD;
                  addr_d   = '0;
                  wcnt_d   = '0;
                  nwords_d = num_words;
                  bcnt_d   = '0;
                  csum_d   = '0;
                  err_clr  = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (byte_acc) begin
               shift_d = {shift_q[15:0], byte_in};
               bcnt_d  = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  word_d  = full_word;
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            wcnt_d = wcnt_q + (ADDR_W+1)'(1);
            csum_d = csum_q ^ word_q;
            // Address only advances when more words follow, so a full
            // DEPTH load finishes at DEPTH-1 without wrapping.
            if (wcnt_d == nwords_q) begin
`ifdef CHECKSUM_EN
               state_d = S_CHK;
`else
               state_d = S_RUN;
`endif
            end else begin
               addr_d  = addr_q + (ADDR_W)'(1);
               state_d = S_LOAD;
            end
         end
`ifdef CHECKSUM_EN
         S_CHK: begin
            if (byte_acc) begin
               shift_d = {shift_q[15:0], byte_in};
               bcnt_d  = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  if (full_word == csum_q) begin
                     state_d = S_RUN;
                  end else begin
                     state_d = S_IDLE;
                     err_set = 1'b1;
                  end
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs derived from the upcoming state
   always_comb begin
      byte_ready_d = (state_d == S_LOAD) || (state_d == S_CHK);
      busy_d       = (state_d == S_LOAD) || (state_d == S_WRITE) || (state_d == S_CHK);
      done_d       = (state_d == S_RUN);
      cpu_rst_d    = (state_d != S_RUN);
      instr_w_en_d = (state_d == S_WRITE);
      instr_in_d   = instr_in_q;
      i_w_addr_d   = i_w_addr_q;
      if (state_d == S_WRITE) begin
         instr_in_d = word_d;
         i_w_addr_d = addr_q;
      end
      err_d = err_q;
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
   end

   assign byte_ready = byte_ready_q;
   assign Instr_IN   = instr_in_q;
   assign Instr_W_en = instr_w_en_q;
   assign I_W_Addr   = i_w_addr_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader.  Inputs are driven on the falling edge,
//   outputs sampled on the falling edge.  A write monitor logs every
//   Instr_W_en strobe.  Define CHECKSUM_EN to exercise the checksum build.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   localparam int ADDR_W = 9;
   localparam int DEPTH  = 512;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic [7:0]        byte_in = '0;
   logic              byte_valid = 1'b0;
   logic              byte_ready;
   logic [31:0]       Instr_IN;
   logic              Instr_W_en;
   logic [ADDR_W-1:0] I_W_Addr;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              err;

   int tests = 0;
   int fails = 0;

   int          wr_cnt = 0;
   logic [31:0] wr_data [0:2047];
   logic [31:0] wr_addr [0:2047];

   imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_words  (num_words),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .Instr_IN   (Instr_IN),
      .Instr_W_en (Instr_W_en),
      .I_W_Addr   (I_W_Addr),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Log each strobe as the strobe cycle ends
   always @(posedge clk) begin
      if (Instr_W_en === 1'b1) begin
         wr_data[wr_cnt[10:0]] <= Instr_IN;
         wr_addr[wr_cnt[10:0]] <= 32'(I_W_Addr);
         wr_cnt                <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      if (gap) begin
         byte_valid = 1'b0;
         tick();
      end
      byte_in    = b;
      byte_valid = 1'b1;
      n = 0;
      while (byte_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("byte_ready_wait", 32'(byte_ready), 32'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      send_byte(w[31:24], gap);
      send_byte(w[23:16], gap);
      send_byte(w[15:8],  gap);
      send_byte(w[7:0],   gap);
   endtask

   task automatic do_start(input int n);
      num_words = (ADDR_W+1)'(n);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [31:0] d, input logic [31:0] a);
      chk({tag, "_wen"},  32'(Instr_W_en), 32'd1);
      chk({tag, "_data"}, Instr_IN, d);
      chk({tag, "_addr"}, 32'(I_W_Addr), a);
      chk({tag, "_rdy"},  32'(byte_ready), 32'd0);
   endtask

   task automatic check_run(input string tag);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
      chk({tag, "_done"},    32'(done), 32'd1);
      chk({tag, "_busy"},    32'(busy), 32'd0);
      chk({tag, "_wen"},     32'(Instr_W_en), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_async_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_async_busy",    32'(busy), 32'd0);
      chk("rst_async_rdy",     32'(byte_ready), 32'd0);
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int base;
      logic [31:0] x;

      @(negedge clk);
      // 1. reset values
      do_reset();
      chk("rst_instr_in", Instr_IN, 32'h0);
      chk("rst_wen",      32'(Instr_W_en), 32'd0);
      chk("rst_addr",     32'(I_W_Addr), 32'd0);
      chk("rst_rdy",      32'(byte_ready), 32'd0);
      chk("rst_cpu_rst",  32'(cpu_rst), 32'd1);
      chk("rst_busy",     32'(busy), 32'd0);
      chk("rst_done",     32'(done), 32'd0);
      chk("rst_err",      32'(err), 32'd0);

      // 2. two-word load
      base = wr_cnt;
      do_start(2);
      chk("t2_busy",  32'(busy), 32'd1);
      chk("t2_rdy",   32'(byte_ready), 32'd1);
      send_word(32'h20010005, 1'b0);
      check_write("t2_w0", 32'h20010005, 32'd0);
      send_word(32'h00000000, 1'b0);
      check_write("t2_w1", 32'h00000000, 32'd1);
      tick();
`ifdef CHECKSUM_EN
      chk("t2_chk_cpu_rst", 32'(cpu_rst), 32'd1);
      send_word(32'h20010005, 1'b0);
`endif
      check_run("t2_run");
      chk("t2_strobes", 32'(wr_cnt - base), 32'd2);
      chk("t2_log_d0", wr_data[base], 32'h20010005);
      chk("t2_log_d1", wr_data[base+1], 32'h00000000);

      // 3. reload from RUN with byte_valid toggling
      base = wr_cnt;
      do_start(2);
      chk("t3_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t3_done",    32'(done), 32'd0);
      chk("t3_busy",    32'(busy), 32'd1);
      send_word(32'h20010005, 1'b1);
      check_write("t3_w0", 32'h20010005, 32'd0);
      send_word(32'h00000000, 1'b1);
      check_write("t3_w1", 32'h00000000, 32'd1);
      tick();
`ifdef CHECKSUM_EN
      send_word(32'h20010005, 1'b1);
`endif
      check_run("t3_run");
      chk("t3_strobes", 32'(wr_cnt - base), 32'd2);

      // 4. illegal lengths from IDLE
      do_reset();
      base = wr_cnt;
      do_start(0);
      chk("t4_err0",     32'(err), 32'd1);
      chk("t4_busy0",    32'(busy), 32'd0);
      chk("t4_cpu_rst0", 32'(cpu_rst), 32'd1);
      do_start(513);
      chk("t4_err513",   32'(err), 32'd1);
      chk("t4_rdy513",   32'(byte_ready), 32'd0);
      chk("t4_cpu_rst513", 32'(cpu_rst), 32'd1);
      tick();
      chk("t4_err_sticky", 32'(err), 32'd1);
      chk("t4_strobes",  32'(wr_cnt - base), 32'd0);

      // 5. rst mid-load, fresh load, then restart from RUN
      do_start(1);
      chk("t5_err_clr", 32'(err), 32'd0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      do_reset();
      chk("t5_rst_done", 32'(done), 32'd0);
      chk("t5_rst_wen",  32'(Instr_W_en), 32'd0);
      base = wr_cnt;
      do_start(1);
      send_word(32'hAABBCCDD, 1'b0);
      check_write("t5_w0", 32'hAABBCCDD, 32'd0);
      tick();
`ifdef CHECKSUM_EN
      send_word(32'hAABBCCDD, 1'b0);
`endif
      check_run("t5_run");
      chk("t5_strobes", 32'(wr_cnt - base), 32'd1);
      do_start(1);
      chk("t5_re_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t5_re_done",    32'(done), 32'd0);
      send_word(32'h11223344, 1'b0);
      check_write("t5_re_w0", 32'h11223344, 32'd0);
      tick();
`ifdef CHECKSUM_EN
      send_word(32'h11223344, 1'b0);
`endif
      check_run("t5_re_run");

`ifdef CHECKSUM_EN
      // 6. checksum behaviour
      do_reset();
      base = wr_cnt;
      do_start(1);
      send_word(32'h12345678, 1'b0);
      check_write("t6_w0", 32'h12345678, 32'd0);
      tick();
      send_word(32'h12345678, 1'b0);
      check_run("t6_match");
      chk("t6_err_ok", 32'(err), 32'd0);
      chk("t6_strobes", 32'(wr_cnt - base), 32'd1);
      do_start(1);
      send_word(32'h12345678, 1'b0);
      tick();
      send_word(32'h00000000, 1'b0);
      chk("t6_bad_err",     32'(err), 32'd1);
      chk("t6_bad_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("t6_bad_done",    32'(done), 32'd0);
      chk("t6_bad_busy",    32'(busy), 32'd0);
      chk("t6_bad_strobes", 32'(wr_cnt - base), 32'd2);

      // full-depth load ends at the last address
      base = wr_cnt;
      x = 32'h0;
      do_start(DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         send_word(32'hA5000000 | 32'(i), 1'b0);
         x = x ^ (32'hA5000000 | 32'(i));
         if (i == DEPTH-1) check_write("t6_last", 32'hA5000000 | 32'(DEPTH-1), 32'd511);
         tick();
      end
      send_word(x, 1'b0);
      check_run("t6_depth_run");
      chk("t6_depth_strobes", 32'(wr_cnt - base), 32'(DEPTH));
      chk("t6_depth_err", 32'(err), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
